// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: three-master round-robin arbiter and multiplexer for the
// 8-bit data memory port. Master 0 = CPU, 1 = stack, 2 = debug/DMA.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; any request is arbitrated at the next edge
// BUSY  | owner_q holds the bus while its req is high; each granted cycle
//       | is one beat, and an unlocked owner can be pre-empted
//
// The design is intentionally Moore on state/owner plus req gating: grant
// follows the owner's req combinationally so a master dropping req sees
// its grant fall in the same cycle.
module data_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic [2:0] wr,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] dout0,
    input  logic [7:0] dout1,
    input  logic [7:0] dout2,
    output logic [2:0] grant,
    output logic [7:0] rd_data,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dout,
    output logic       mem_wr,
    output logic       mem_rd,
    input  logic [7:0] mem_din
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
    localparam logic [3:0] BEATS_MAX = 4'd15;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] beats_q, beats_d;

    logic       owner_req;
    logic       owner_lock;
    logic [2:0] others;
    logic       burst_done;

    // Round-robin pick: scan masters starting after 'prev', wrapping mod 3.
    // An out-of-range 'prev' restarts the scan at master 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] prev);
        logic [1:0] c0, c1, c2;
        logic [1:0] pick;
        c0 = (prev == 2'd0) ? 2'd1 : (prev == 2'd1) ? 2'd2 : 2'd0;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (r[c0])
            pick = c0;
        else if (r[c1])
            pick = c1;
        else if (r[c2])
            pick = c2;
        else
            pick = 2'd0;
        return pick;
    endfunction

    // Owner's own request/lock and the requests from everyone else.
    always_comb begin
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        others     = req;
        case (owner_q)
            2'd0: begin
                owner_req  = req[0];
                owner_lock = lock[0];
                others     = {req[2:1], 1'b0};
            end
            2'd1: begin
                owner_req  = req[1];
                owner_lock = lock[1];
                others     = {req[2], 1'b0, req[0]};
            end
            2'd2: begin
                owner_req  = req[2];
                owner_lock = lock[2];
                others     = {1'b0, req[1:0]};
            end
            default: begin
                owner_req  = 1'b0;
                owner_lock = 1'b0;
                others     = req;
            end
        endcase
    end

    // The current beat is the owner's MAX_BURST-th (or later) granted beat.
    assign burst_done = ({1'b0, beats_q} + 5'd1) >= BURST_LIM;

    // Next-state logic: arbitration, release hand-over and pre-emption.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = rr_pick(req, last_q);
                    beats_d = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (owner_q == 2'd3) begin
                    state_d = IDLE;
                end else if (!owner_req) begin
                    last_d = owner_q;
                    if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                        beats_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (burst_done && !owner_lock && (|others)) begin
                    // Pre-empted owner keeps req high and is re-queued by
                    // the round-robin order starting after itself.
                    last_d  = owner_q;
                    owner_d = rr_pick(others, owner_q);
                    beats_d = 4'd0;
                end else if (beats_q != BEATS_MAX) begin
                    beats_d = beats_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; last=2 lets the CPU
    // win a tie right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            beats_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // Grant and memory-port mux from the granted owner; all zero otherwise.
    always_comb begin
        grant    = 3'b000;
        mem_addr = 8'h00;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        if (state_q == BUSY && owner_req) begin
            case (owner_q)
                2'd0: begin
                    grant    = 3'b001;
                    mem_addr = addr0;
                    mem_dout = dout0;
                    mem_wr   = wr[0];
                    mem_rd   = ~wr[0];
                end
                2'd1: begin
                    grant    = 3'b010;
                    mem_addr = addr1;
                    mem_dout = dout1;
                    mem_wr   = wr[1];
                    mem_rd   = ~wr[1];
                end
                2'd2: begin
                    grant    = 3'b100;
                    mem_addr = addr2;
                    mem_dout = dout2;
                    mem_wr   = wr[2];
                    mem_rd   = ~wr[2];
                end
                default: begin
                    grant    = 3'b000;
                end
            endcase
        end
    end

    assign rd_data = mem_din;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter. Two instances share stimulus:
// dut_a with MAX_BURST=4 and dut_b with MAX_BURST=1, each with its own
// combinational-read RAM model.
module tb_data_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req, lock, wr;
    logic [7:0] addr0, addr1, addr2, dout0, dout1, dout2;

    logic [2:0] grant_a, grant_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic [7:0] mem_addr_a, mem_addr_b, mem_dout_a, mem_dout_b;
    logic       mem_wr_a, mem_wr_b, mem_rd_a, mem_rd_b;
    logic [7:0] mem_din_a, mem_din_b;

    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(.MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wr(wr),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .grant(grant_a), .rd_data(rd_data_a), .mem_addr(mem_addr_a),
        .mem_dout(mem_dout_a), .mem_wr(mem_wr_a), .mem_rd(mem_rd_a),
        .mem_din(mem_din_a)
    );

    data_bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wr(wr),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .grant(grant_b), .rd_data(rd_data_b), .mem_addr(mem_addr_b),
        .mem_dout(mem_dout_b), .mem_wr(mem_wr_b), .mem_rd(mem_rd_b),
        .mem_din(mem_din_b)
    );

    assign mem_din_a = ram_a[mem_addr_a];
    assign mem_din_b = ram_b[mem_addr_b];

    always @(posedge clk) begin
        if (mem_wr_a) ram_a[mem_addr_a] <= mem_dout_a;
        if (mem_wr_b) ram_b[mem_addr_b] <= mem_dout_b;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req   = 3'b000;
        lock  = 3'b000;
        wr    = 3'b000;
        addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00;
        dout0 = 8'h00; dout1 = 8'h00; dout2 = 8'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'h00;
            ram_b[i] = 8'h00;
        end
        ram_a[8'h00] = 8'h77;
        ram_a[8'h40] = 8'hA5;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check_val("rst_grant",    grant_a,    3'b000);
        check_val("rst_mem_addr", mem_addr_a, 8'h00);
        check_val("rst_mem_dout", mem_dout_a, 8'h00);
        check_val("rst_mem_wr",   mem_wr_a,   1'b0);
        check_val("rst_mem_rd",   mem_rd_a,   1'b0);
        check_val("rst_rd_data",  rd_data_a,  8'h77);

        // Single read
        do_reset();
        wr = 3'b000; addr0 = 8'h40; req = 3'b001;
        sample();
        check_val("rd_lat_idle", grant_a, 3'b000);
        tick();
        sample();
        check_val("rd_grant",   grant_a,    3'b001);
        check_val("rd_mem_rd",  mem_rd_a,   1'b1);
        check_val("rd_mem_wr",  mem_wr_a,   1'b0);
        check_val("rd_addr",    mem_addr_a, 8'h40);
        check_val("rd_data",    rd_data_a,  8'hA5);
        tick();
        req = 3'b000;
        sample();
        check_val("rd_drop_grant", grant_a,  3'b000);
        check_val("rd_drop_rd",    mem_rd_a, 1'b0);

        // Tie after reset
        do_reset();
        addr0 = 8'h01; addr1 = 8'h02; addr2 = 8'h03; req = 3'b111;
        tick();
        sample();
        check_val("tie_cpu", grant_a, 3'b001);
        tick();
        req = 3'b110;
        sample();
        check_val("tie_rel0", grant_a, 3'b000);
        tick();
        sample();
        check_val("tie_stack", grant_a, 3'b010);
        check_val("tie_stack_addr", mem_addr_a, 8'h02);
        tick();
        req = 3'b100;
        sample();
        check_val("tie_rel1", grant_a, 3'b000);
        tick();
        sample();
        check_val("tie_dbg", grant_a, 3'b100);
        tick();
        req = 3'b000;

        // Locked stack push on the MAX_BURST=1 instance
        do_reset();
        req = 3'b010; lock = 3'b010; wr = 3'b010;
        addr1 = 8'h3F; dout1 = 8'hAA; addr0 = 8'h22;
        tick();
        req = 3'b011;
        sample();
        check_val("lk_beat1_grant", grant_b,    3'b010);
        check_val("lk_beat1_wr",    mem_wr_b,   1'b1);
        check_val("lk_beat1_addr",  mem_addr_b, 8'h3F);
        check_val("lk_beat1_dout",  mem_dout_b, 8'hAA);
        tick();
        addr1 = 8'h0F; dout1 = 8'hBB;
        sample();
        check_val("lk_beat2_grant", grant_b,    3'b010);
        check_val("lk_beat2_addr",  mem_addr_b, 8'h0F);
        tick();
        req = 3'b001; lock = 3'b000;
        sample();
        check_val("lk_rel_grant", grant_b,      3'b000);
        check_val("lk_ram_3f",    ram_b[8'h3F], 8'hAA);
        check_val("lk_ram_0f",    ram_b[8'h0F], 8'hBB);
        tick();
        sample();
        check_val("lk_cpu_grant", grant_b,    3'b001);
        check_val("lk_cpu_addr",  mem_addr_b, 8'h22);
        tick();
        req = 3'b000;

        // Pre-emption: dut_a after 4 CPU beats, dut_b after every beat
        do_reset();
        addr0 = 8'h50; addr1 = 8'h60; req = 3'b011;
        tick();
        sample();
        check_val("pe_c1_a", grant_a, 3'b001);
        check_val("pe_c1_b", grant_b, 3'b001);
        tick();
        sample();
        check_val("pe_c2_a", grant_a, 3'b001);
        check_val("pe_c2_b", grant_b, 3'b010);
        tick();
        sample();
        check_val("pe_c3_a", grant_a, 3'b001);
        check_val("pe_c3_b", grant_b, 3'b001);
        tick();
        sample();
        check_val("pe_c4_a",    grant_a,    3'b001);
        check_val("pe_c4_addr", mem_addr_a, 8'h50);
        tick();
        sample();
        check_val("pe_c5_a",    grant_a,    3'b010);
        check_val("pe_c5_addr", mem_addr_a, 8'h60);
        tick();
        req = 3'b001;
        sample();
        check_val("pe_rel_a", grant_a, 3'b000);
        tick();
        sample();
        check_val("pe_regrant_a", grant_a, 3'b001);
        tick();
        req = 3'b000;

        // Reset in the middle of a debug write burst
        do_reset();
        wr = 3'b100; addr2 = 8'h70; dout2 = 8'h11; req = 3'b100;
        tick();
        sample();
        check_val("mb_beat1", grant_a, 3'b100);
        tick();
        addr2 = 8'h71; dout2 = 8'h22; rst_n = 1'b0;
        sample();
        check_val("mb_beat2", grant_a, 3'b100);
        tick();
        addr2 = 8'h72; dout2 = 8'h33;
        sample();
        check_val("mb_rst_grant", grant_a,    3'b000);
        check_val("mb_rst_wr",    mem_wr_a,   1'b0);
        check_val("mb_rst_rd",    mem_rd_a,   1'b0);
        check_val("mb_rst_addr",  mem_addr_a, 8'h00);
        check_val("mb_rst_dout",  mem_dout_a, 8'h00);
        tick();
        addr0 = 8'h05; req = 3'b101; rst_n = 1'b1;
        tick();
        sample();
        check_val("mb_cpu_first", grant_a,      3'b001);
        check_val("mb_ram_70",    ram_a[8'h70], 8'h11);
        check_val("mb_ram_72",    ram_a[8'h72], 8'h00);
        tick();
        req = 3'b000;

        // Write mux: only the debug master's data reaches the RAM
        do_reset();
        wr = 3'b111;
        addr0 = 8'h11; addr1 = 8'h12; addr2 = 8'h10;
        dout0 = 8'hC0; dout1 = 8'hC1; dout2 = 8'h5A;
        req = 3'b100;
        tick();
        sample();
        check_val("wm_grant", grant_a,    3'b100);
        check_val("wm_wr",    mem_wr_a,   1'b1);
        check_val("wm_rd",    mem_rd_a,   1'b0);
        check_val("wm_addr",  mem_addr_a, 8'h10);
        check_val("wm_dout",  mem_dout_a, 8'h5A);
        tick();
        req = 3'b000;
        sample();
        check_val("wm_ram_10", ram_a[8'h10], 8'h5A);
        check_val("wm_ram_11", ram_a[8'h11], 8'h00);
        check_val("wm_ram_12", ram_a[8'h12], 8'h00);
        check_val("wm_drop",   grant_a,      3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
